// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared source encodings and result record for the CDB arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

    localparam int CDB_VAL_W = 32;
    localparam int CDB_ROB_W = 4;

    localparam logic SRC_ALU  = 1'b0;
    localparam logic SRC_LOAD = 1'b1;

    typedef struct packed {
        logic [CDB_VAL_W-1:0] val;
        logic [CDB_ROB_W-1:0] tag;
    } cdb_result_t;

endpackage

`default_nettype wire

// File: rtl/cdb_fifo.sv
// ============================================================================
//  Module      : cdb_fifo
//  Description : Small per-source result FIFO with push/pop/clear and count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en) begin
            if (clear) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= din;
                    wr_ptr_q        <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_d;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Round-robin arbiter of ALU and load results onto the CDB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    // Must equal CDB_ROB_W so the tag fits the shared result record.
    parameter int ROB_WIDTH = CDB_ROB_W,
    parameter int DEPTH     = 2
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 clearIn,
    input  logic                 aluFlag,
    input  logic [31:0]          aluVal,
    input  logic [ROB_WIDTH-1:0] aluDest,
    output logic                 aluReady,
    input  logic                 loadFlag,
    input  logic [31:0]          loadVal,
    input  logic [ROB_WIDTH-1:0] loadDest,
    output logic                 loadReady,
    output logic                 outFlag,
    output logic [31:0]          outVal,
    output logic [ROB_WIDTH-1:0] outDest,
    output logic                 outSrc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    cdb_result_t   alu_in, load_in, alu_head, load_head;
    cdb_result_t   alu_cand, load_cand, win_res;
    logic [CW-1:0] alu_cnt, load_cnt;
    logic          alu_nonempty, load_nonempty, alu_valid, load_valid;
    logic          grant, win_src, alu_push, alu_pop, load_push, load_pop;

    logic          out_flag_q, out_src_q, last_src_q;
    cdb_result_t   out_res_q;

    assign alu_in        = '{val: aluVal,  tag: aluDest};
    assign load_in       = '{val: loadVal, tag: loadDest};
    assign alu_nonempty  = (alu_cnt  != '0);
    assign load_nonempty = (load_cnt != '0);
    assign alu_valid     = alu_nonempty  | aluFlag;
    assign load_valid    = load_nonempty | loadFlag;
    assign alu_cand      = alu_nonempty  ? alu_head  : alu_in;
    assign load_cand     = load_nonempty ? load_head : load_in;
    assign aluReady      = (alu_cnt  != FULL);
    assign loadReady     = (load_cnt != FULL);

    always_comb begin
        grant   = alu_valid | load_valid;
        win_src = (alu_valid && load_valid) ? ~last_src_q : load_valid;
        win_res = (win_src == SRC_LOAD) ? load_cand : alu_cand;
    end

    // A winner with an empty FIFO consumes its input directly (bypass), so no push.
    always_comb begin
        alu_pop   = grant && (win_src == SRC_ALU)  && alu_nonempty;
        load_pop  = grant && (win_src == SRC_LOAD) && load_nonempty;
        alu_push  = aluFlag  && aluReady  && !(grant && (win_src == SRC_ALU)  && !alu_nonempty);
        load_push = loadFlag && loadReady && !(grant && (win_src == SRC_LOAD) && !load_nonempty);
    end

    cdb_fifo #(.DEPTH(DEPTH), .W($bits(cdb_result_t))) u_alu_fifo (
        .clk   (clockIn),
        .rst_n (resetIn),
        .en    (readyIn),
        .clear (clearIn),
        .push  (alu_push),
        .pop   (alu_pop),
        .din   (alu_in),
        .head  (alu_head),
        .count (alu_cnt)
    );

    cdb_fifo #(.DEPTH(DEPTH), .W($bits(cdb_result_t))) u_load_fifo (
        .clk   (clockIn),
        .rst_n (resetIn),
        .en    (readyIn),
        .clear (clearIn),
        .push  (load_push),
        .pop   (load_pop),
        .din   (load_in),
        .head  (load_head),
        .count (load_cnt)
    );

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            out_flag_q <= 1'b0;
            out_src_q  <= SRC_ALU;
            out_res_q  <= '0;
            last_src_q <= SRC_LOAD;
        end else if (readyIn) begin
            if (clearIn) begin
                out_flag_q <= 1'b0;
            end else if (grant) begin
                out_flag_q <= 1'b1;
                out_src_q  <= win_src;
                out_res_q  <= win_res;
                last_src_q <= win_src;
            end else begin
                out_flag_q <= 1'b0;
            end
        end
    end

    assign outFlag = out_flag_q;
    assign outVal  = out_res_q.val;
    assign outDest = out_res_q.tag;
    assign outSrc  = out_src_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1, clr = 1'b0;
    logic        af = 1'b0, lf = 1'b0;
    logic [31:0] av = '0, lv = '0;
    logic [3:0]  ad = '0, ld = '0;
    logic        aluReady, loadReady, outFlag, outSrc;
    logic [31:0] outVal;
    logic [3:0]  outDest;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per source, items are {value, tag}.
    logic [35:0] qa[$];
    logic [35:0] ql[$];
    logic        m_flag, m_src, m_last;
    logic [31:0] m_val;
    logic [3:0]  m_dest;

    cdb_arbiter #(.ROB_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clockIn   (clk),
        .resetIn   (rst_n),
        .readyIn   (rdy),
        .clearIn   (clr),
        .aluFlag   (af),
        .aluVal    (av),
        .aluDest   (ad),
        .aluReady  (aluReady),
        .loadFlag  (lf),
        .loadVal   (lv),
        .loadDest  (ld),
        .loadReady (loadReady),
        .outFlag   (outFlag),
        .outVal    (outVal),
        .outDest   (outDest),
        .outSrc    (outSrc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && rdy && !clr) begin
            assert (!(af && !aluReady))  else $error("FAIL proto_alu flag driven while not ready");
            assert (!(lf && !loadReady)) else $error("FAIL proto_load flag driven while not ready");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        ql.delete();
        m_flag = 1'b0; m_val = '0; m_dest = '0; m_src = 1'b0; m_last = 1'b1;
    endtask

    // Arrivals join their queue first; the winner then takes its queue front.
    task automatic model_step();
        logic        ca, cl, pick;
        logic [35:0] item;
        if (!rdy) return;
        if (clr) begin
            qa.delete();
            ql.delete();
            m_flag = 1'b0;
            return;
        end
        if (af && qa.size() < DEPTH) qa.push_back({av, ad});
        if (lf && ql.size() < DEPTH) ql.push_back({lv, ld});
        ca = (qa.size() > 0);
        cl = (ql.size() > 0);
        if (ca || cl) begin
            pick   = (ca && cl) ? !m_last : cl;
            item   = pick ? ql.pop_front() : qa.pop_front();
            m_flag = 1'b1;
            m_val  = item[35:4];
            m_dest = item[3:0];
            m_src  = pick;
            m_last = pick;
        end else begin
            m_flag = 1'b0;
        end
    endtask

    task automatic compare();
        chk("outFlag",   {31'b0, outFlag},   {31'b0, m_flag});
        chk("outVal",    outVal,             m_val);
        chk("outDest",   {28'b0, outDest},   {28'b0, m_dest});
        chk("outSrc",    {31'b0, outSrc},    {31'b0, m_src});
        chk("aluReady",  {31'b0, aluReady},  {31'b0, qa.size() != DEPTH});
        chk("loadReady", {31'b0, loadReady}, {31'b0, ql.size() != DEPTH});
    endtask

    // Called at a negedge with inputs set; returns at the next negedge after checking.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; clr = 1'b0; af = 1'b0; lf = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare();
    endtask

    task automatic single_alu(input string tag);
        af = 1'b1; av = 32'h0000_1234; ad = 4'd3;
        tick();
        af = 1'b0;
        chk({tag, "_flag"}, {31'b0, outFlag}, 32'd1);
        chk({tag, "_val"},  outVal,           32'h1234);
        chk({tag, "_dest"}, {28'b0, outDest}, 32'd3);
        chk({tag, "_src"},  {31'b0, outSrc},  32'd0);
    endtask

    initial begin
        logic [31:0] a_drv, l_drv, a_exp, l_exp, snap_val;
        logic [3:0]  snap_dest;
        logic        snap_flag, snap_src, prev_src, have_prev, saw_a, saw_l;

        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_flag",      {31'b0, outFlag},   32'd0);
        chk("rst_val",       outVal,             32'd0);
        chk("rst_dest",      {28'b0, outDest},   32'd0);
        chk("rst_src",       {31'b0, outSrc},    32'd0);
        chk("rst_aluReady",  {31'b0, aluReady},  32'd1);
        chk("rst_loadReady", {31'b0, loadReady}, 32'd1);

        // Single ALU result
        single_alu("single");
        tick();
        chk("single_idle_flag", {31'b0, outFlag}, 32'd0);

        // Simultaneous tie after reset: ALU first, then LOAD
        do_reset();
        af = 1'b1; av = 32'hA; ad = 4'd1;
        lf = 1'b1; lv = 32'hB; ld = 4'd2;
        tick();
        af = 1'b0; lf = 1'b0;
        chk("tie1_val",       outVal,             32'hA);
        chk("tie1_src",       {31'b0, outSrc},    32'd0);
        chk("tie1_loadReady", {31'b0, loadReady}, 32'd1);
        tick();
        chk("tie2_val",  outVal,           32'hB);
        chk("tie2_dest", {28'b0, outDest}, 32'd2);
        chk("tie2_src",  {31'b0, outSrc},  32'd1);

        // Saturation: both sources push whenever ready
        do_reset();
        a_drv = 32'd1; l_drv = 32'h1000; a_exp = 32'd1; l_exp = 32'h1000;
        have_prev = 1'b0; prev_src = 1'b0; saw_a = 1'b0; saw_l = 1'b0;
        for (int i = 0; i < 16; i++) begin
            af = (qa.size() != DEPTH); av = a_drv; ad = a_drv[3:0];
            lf = (ql.size() != DEPTH); lv = l_drv; ld = l_drv[3:0];
            if (af) a_drv++;
            if (lf) l_drv++;
            tick();
            chk("sat_flag", {31'b0, outFlag}, 32'd1);
            if (have_prev) chk("sat_alternate", {31'b0, outSrc}, {31'b0, !prev_src});
            if (outSrc) begin
                chk("sat_load_seq", outVal, l_exp); l_exp++;
            end else begin
                chk("sat_alu_seq", outVal, a_exp); a_exp++;
            end
            prev_src = outSrc; have_prev = 1'b1;
            saw_a |= !aluReady; saw_l |= !loadReady;
        end
        chk("sat_alu_backpressure",  {31'b0, saw_a}, 32'd1);
        chk("sat_load_backpressure", {31'b0, saw_l}, 32'd1);

        // Flush with both flags high
        af = 1'b1; av = 32'hDEAD; lf = 1'b1; lv = 32'hBEEF; clr = 1'b1;
        tick();
        clr = 1'b0; af = 1'b0; lf = 1'b0;
        chk("flush_flag",      {31'b0, outFlag},   32'd0);
        chk("flush_aluReady",  {31'b0, aluReady},  32'd1);
        chk("flush_loadReady", {31'b0, loadReady}, 32'd1);
        repeat (4) begin
            tick();
            chk("flush_drained", {31'b0, outFlag}, 32'd0);
        end

        // Freeze with two results pending
        do_reset();
        af = 1'b1; av = 32'h100; ad = 4'd5; lf = 1'b1; lv = 32'h200; ld = 4'd6;
        tick();
        af = 1'b1; av = 32'h101; ad = 4'd7; lf = 1'b1; lv = 32'h202; ld = 4'd8;
        tick();
        af = 1'b0; lf = 1'b0;
        chk("frz_pre_val", outVal, 32'h200);
        snap_flag = outFlag; snap_val = outVal; snap_dest = outDest; snap_src = outSrc;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            af = $urandom_range(1); lf = $urandom_range(1); clr = (i == 1);
            av = $urandom; lv = $urandom;
            tick();
            chk("frz_flag", {31'b0, outFlag},   {31'b0, snap_flag});
            chk("frz_val",  outVal,             snap_val);
            chk("frz_dest", {28'b0, outDest},   {28'b0, snap_dest});
            chk("frz_src",  {31'b0, outSrc},    {31'b0, snap_src});
        end
        idle_inputs();
        tick();
        chk("frz_post1_val", outVal,          32'h101);
        chk("frz_post1_src", {31'b0, outSrc}, 32'd0);
        tick();
        chk("frz_post2_val", outVal,          32'h202);
        chk("frz_post2_src", {31'b0, outSrc}, 32'd1);
        tick();
        chk("frz_post3_flag", {31'b0, outFlag}, 32'd0);

        // Asynchronous reset while a broadcast is valid
        do_reset();
        single_alu("pre_areset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_flag", {31'b0, outFlag}, 32'd0);
        chk("areset_val",  outVal,           32'd0);
        chk("areset_dest", {28'b0, outDest}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        single_alu("post_areset");
        tick();
        chk("post_areset_idle", {31'b0, outFlag}, 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(9) != 0);
            clr = ($urandom_range(24) == 0);
            af  = (qa.size() != DEPTH) && ($urandom_range(2) != 0);
            lf  = (ql.size() != DEPTH) && ($urandom_range(2) != 0);
            av  = $urandom; ad = 4'($urandom);
            lv  = $urandom; ld = 4'($urandom);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
